// File: rtl/burst_arb_pkg.sv
// Shared types and helpers for the burst stream arbiter.
// Imported by the arbiter top and its round-robin selector.
package burst_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StDone
  } state_e;

  // Index width for a requester count; never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/burst_stream_arbiter_if.sv
// Requester and stream signals of the burst stream arbiter.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface burst_stream_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned NUM_REQ    = 4
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic                          valid_out;
  logic                          ready_in;
  logic [ADDR_WIDTH-1:0]         addr;
  logic [DATA_WIDTH-1:0]         data;
  logic                          last;

  modport master (
    input  req, req_addr, req_len, ready_in,
    output gnt, done, valid_out, addr, data, last
  );

  modport slave (
    output req, req_addr, req_len, ready_in,
    input  gnt, done, valid_out, addr, data, last
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
// The pointer register is owned by the caller.
module rr_arbiter
  import burst_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [idx_w(NUM_REQ)-1:0]   ptr,
  output logic [NUM_REQ-1:0]          win_oh,
  output logic [idx_w(NUM_REQ)-1:0]   win_idx
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);

  always_comb begin
    int unsigned k;
    logic        found;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[k]) begin
        found     = 1'b1;
        win_oh[k] = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/burst_stream_arbiter.sv
// Shares one addr/data stream between NUM_REQ burst requesters using round-robin
// arbitration; every output is registered.
module burst_stream_arbiter
  import burst_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic                   clk,
  input  logic                   sys_rst,
  burst_stream_arbiter_if.master bus,
  output logic                   busy
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);

  state_e                state_q;
  logic [IDX_W-1:0]      ptr_q;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      ptr_nxt;
  logic [NUM_REQ-1:0]    win_oh;
  logic [ADDR_WIDTH-1:0] start_q;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  win_len;
  logic [LEN_WIDTH-1:0]  beat_q;
  logic [LEN_WIDTH-1:0]  beat_nxt;
  logic [LEN_WIDTH-1:0]  len_m1;
  logic                  is_final;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  always_comb begin
    win_addr = '0;
    win_len  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_len  = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  assign ptr_nxt  = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
  assign beat_nxt = beat_q + LEN_WIDTH'(1);
  assign len_m1   = len_q - LEN_WIDTH'(1);
  assign is_final = (beat_q == len_m1);

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      start_q       <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      bus.gnt       <= '0;
      bus.done      <= '0;
      bus.valid_out <= 1'b0;
      bus.addr      <= '0;
      bus.data      <= '0;
      bus.last      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|bus.req) begin
            start_q <= win_addr;
            len_q   <= win_len;
            beat_q  <= '0;
            ptr_q   <= ptr_nxt;
            busy    <= 1'b1;
            if (win_len != '0) begin
              state_q       <= StBurst;
              bus.gnt       <= win_oh;
              bus.valid_out <= 1'b1;
              bus.addr      <= win_addr;
              bus.data      <= '0;
              bus.last      <= (win_len == LEN_WIDTH'(1));
            end else begin
              // Empty burst: report completion without issuing any beat.
              state_q  <= StDone;
              bus.done <= win_oh;
            end
          end
        end
        StBurst: begin
          if (bus.ready_in) begin
            if (is_final) begin
              state_q       <= StDone;
              bus.done      <= bus.gnt;
              bus.gnt       <= '0;
              bus.valid_out <= 1'b0;
              bus.addr      <= '0;
              bus.data      <= '0;
              bus.last      <= 1'b0;
            end else begin
              beat_q   <= beat_nxt;
              bus.addr <= start_q + ADDR_WIDTH'(beat_nxt);
              bus.data <= DATA_WIDTH'(beat_nxt);
              bus.last <= (beat_nxt == len_m1);
            end
          end
        end
        StDone: begin
          state_q  <= StIdle;
          bus.done <= '0;
          busy     <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
